// File: rtl/baud_fifo_pkg.sv
// rtl/baud_fifo_pkg.sv - Shared defaults and pointer-width helper for baud_fifo
package baud_fifo_pkg;

   localparam int DEFAULT_BAUD_WORD = 16;
   localparam int DEFAULT_WIDTH     = 8;
   localparam int DEFAULT_DEPTH     = 16;

   // log2 of a power-of-two depth, never below one bit
   function automatic int ptr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/baud_fifo_baud_generator.sv
// rtl/baud_fifo_baud_generator.sv - Baud tick counter; BAUD_HALF_START_EN puts the first tick at mid-bit
module baud_generator
   import baud_fifo_pkg::*;
#(
   parameter int BAUD_WORD = DEFAULT_BAUD_WORD
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [BAUD_WORD-1:0] baud,
   output logic                 tick
);

   logic [BAUD_WORD-1:0] cnt;
   logic [BAUD_WORD-1:0] term;

`ifdef BAUD_HALF_START_EN
   logic                 first;
   logic [BAUD_WORD-1:0] span;

   // The first period after enable is half a bit so later ticks land mid-bit
   always_comb begin
      span = first ? (baud >> 1) : baud;
      term = (span <= BAUD_WORD'(1)) ? '0 : span - BAUD_WORD'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first <= 1'b1;
      end else if (!en) begin
         first <= 1'b1;
      end else if (cnt >= term) begin
         first <= 1'b0;
      end
   end
`else
   always_comb begin
      term = (baud <= BAUD_WORD'(1)) ? '0 : baud - BAUD_WORD'(1);
   end
`endif

   // >= so a divisor lowered below the running count wraps at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt >= term) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + BAUD_WORD'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/baud_fifo.sv
// rtl/baud_fifo.sv - Baud tick generator plus first-word-fall-through FIFO (option: BAUD_HALF_START_EN)
module baud_fifo
   import baud_fifo_pkg::*;
#(
   parameter int BAUD_WORD = DEFAULT_BAUD_WORD,
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [BAUD_WORD-1:0] baud_i,
   output logic                 baudClk_o,
   input  logic                 wr_i,
   input  logic                 rd_i,
   input  logic [WIDTH-1:0]     data_i,
   output logic [WIDTH-1:0]     data_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = PW + 1;

   baud_generator #(.BAUD_WORD(BAUD_WORD)) u_baud (
      .clk  (clk_i),
      .rst  (rst_i),
      .en   (en_i),
      .baud (baud_i),
      .tick (baudClk_o)
   );

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             push;
   logic             pop;

   // When full, a concurrent pop frees the head slot that this push refills
   always_comb begin
      push       = wr_i && (!full_o || rd_i);
      pop        = rd_i && !empty_o;
      count_next = count;
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full_o  <= 1'b0;
         empty_o <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count   <= count_next;
         full_o  <= (count_next == CW'(DEPTH));
         empty_o <= (count_next == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= data_i;
   end

   assign data_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_baud_fifo.sv
// tb/tb_baud_fifo.sv - Self-checking bench for baud_fifo against a queue/arithmetic model
module tb_baud_fifo;
   localparam int BW = 16;
   localparam int W  = 8;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic          wr  = 1'b0;
   logic          rd  = 1'b0;
   logic [BW-1:0] baud = '0;
   logic [W-1:0]  din  = '0;
   logic          baud_clk;
   logic [W-1:0]  dout;
   logic          full;
   logic          empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   baud_fifo #(.BAUD_WORD(BW), .WIDTH(W), .DEPTH(D)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .baud_i    (baud),
      .baudClk_o (baud_clk),
      .wr_i      (wr),
      .rd_i      (rd),
      .data_i    (din),
      .data_o    (dout),
      .full_o    (full),
      .empty_o   (empty)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [W-1:0] q[$];
   int  k = 0;
   bit  exp_tick = 1'b0;
   bit  do_push, do_pop;

   // Tick due n enabled edges after enable, for a constant divisor b
   function automatic bit tick_due(input int n, input int b);
      int p;
      int h;
      p = (b < 1) ? 1 : b;
      h = ((b / 2) < 1) ? 1 : b / 2;
`ifdef BAUD_HALF_START_EN
      return (n >= h) && (((n - h) % p) == 0);
`else
      if (h < 0) return 1'b0;
      return (n % p) == 0;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         k        = 0;
         exp_tick = 1'b0;
      end else begin
         if (!en) begin
            k        = 0;
            exp_tick = 1'b0;
         end else begin
            k++;
            exp_tick = tick_due(k, int'(baud));
         end
         do_pop  = rd && (q.size() > 0);
         do_push = wr && ((q.size() < D) || rd);
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(din);
      end
   end

   always @(negedge clk) begin
      check("tick", baud_clk, exp_tick);
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == D);
      check("data", dout, (q.size() == 0) ? 8'h00 : q[0]);
   end

   initial begin
      int pulses[$];
      int exp_p[3];
      int first_re;
`ifdef BAUD_HALF_START_EN
      exp_p    = '{5, 15, 25};
      first_re = 3;
`else
      exp_p    = '{10, 20, 30};
      first_re = 7;
`endif
      repeat (3) @(negedge clk);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_data", dout, 0);
      check("rst_tick", baud_clk, 0);
      rst = 1'b0;

      @(negedge clk);
      baud = 10;
      en   = 1'b1;
      for (int i = 1; i <= 35; i++) begin
         @(posedge clk);
         #1;
         if (baud_clk) pulses.push_back(i);
      end
      @(negedge clk);
      en = 1'b0;
      check("pulse_count", pulses.size(), 3);
      for (int i = 0; i < 3; i++)
         check("pulse_at", (i < pulses.size()) ? pulses[i] : -1, exp_p[i]);

      pulses.delete();
      @(negedge clk);
      baud = 7;
      en   = 1'b1;
      repeat (4) @(negedge clk);
      en = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         if (baud_clk) pulses.push_back(i);
      end
      check("disabled_pulses", pulses.size(), 0);
      @(negedge clk);
      en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (baud_clk) pulses.push_back(i);
      end
      check("reenable_first", (pulses.size() > 0) ? pulses[0] : -1, first_re);

      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         en = 1'b0;
         pulses.delete();
         @(negedge clk);
         baud = BW'(b);
         en   = 1'b1;
         for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (baud_clk) pulses.push_back(i);
         end
         check("every_cycle", pulses.size(), 5);
      end
      @(negedge clk);
      en = 1'b0;

      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      check("rd_empty_ignored", empty, 1);
      for (int i = 0; i < 16; i++) begin
         wr  = 1'b1;
         din = W'(8'h11 + i);
         @(negedge clk);
      end
      check("full_after_16", full, 1);
      check("head_after_16", dout, 8'h11);
      din = 8'hAA;
      @(negedge clk);
      wr = 1'b0;
      check("push17_full", full, 1);
      check("push17_head", dout, 8'h11);
      wr  = 1'b1;
      rd  = 1'b1;
      din = 8'h30;
      @(negedge clk);
      wr = 1'b0;
      rd = 1'b0;
      check("both_full_full", full, 1);
      check("both_full_head", dout, 8'h12);
      for (int i = 0; i < 16; i++) begin
         check("pop_order", dout, (i < 15) ? 8'h12 + i : 8'h30);
         rd = 1'b1;
         @(negedge clk);
      end
      rd = 1'b0;
      check("drained_empty", empty, 1);
      check("drained_data", dout, 8'h00);
      wr  = 1'b1;
      rd  = 1'b1;
      din = 8'h55;
      @(negedge clk);
      rd = 1'b0;
      check("both_empty_empty", empty, 0);
      check("both_empty_data", dout, 8'h55);
      din = 8'h66;
      @(negedge clk);
      rd  = 1'b1;
      din = 8'h77;
      @(negedge clk);
      wr = 1'b0;
      rd = 1'b0;
      check("both_partial_head", dout, 8'h66);

      baud = 1;
      en   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr  = 1'b1;
         din = W'(8'hA0 + i);
         @(negedge clk);
      end
      wr = 1'b0;
      check("pre_rst_tick", baud_clk, 1);
      check("pre_rst_empty", empty, 0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_empty", empty, 1);
      check("async_rst_full", full, 0);
      check("async_rst_data", dout, 8'h00);
      check("async_rst_tick", baud_clk, 0);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
